cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the single unified RAM port between the instruction cache and the data cache in the MIPS CPU memory hierarchy. Registered grant with dcache priority. Locks the grant to the dcache for a full two-word block transfer (write-back or load), so icache fetches never interleave with a block. A starvation counter forces an icache grant after a configurable number of consecutive dcache blocks. Sits between the icache/dcache controllers and the RAM model; the caches see only a per-requester wait signal.

## Interface
- DBLK_WORDS, 2: words per dcache block; length of the dcache grant lock.
- STARVE_MAX, 4: completed dcache blocks allowed while iREN is pending before icache is forced first.

- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low only in the cycle its access completes.
- iload  out  32  read data to icache; equals ramload.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low only in the cycle its access completes.
- dload  out  32  read data to dcache; equals ramload.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.

## Operation
- The FSM (arb_state_t) has three states: ARB_IDLE, ARB_IGNT, ARB_DGNT.
- Counters: word_cnt holds $clog2(DBLK_WORDS) bits; starve_cnt holds $clog2(STARVE_MAX+1) bits and saturates.

Transitions from ARB_IDLE:
- If (dREN|dWEN) and !(iREN && starve_cnt==STARVE_MAX), go to ARB_DGNT.
- Else if iREN, go to ARB_IGNT.
- Otherwise stay in ARB_IDLE.

Transitions from ARB_IGNT:
- On ramstate==ACCESS, go to ARB_IDLE and clear starve_cnt.
- If iREN drops before ACCESS, go to ARB_IDLE.

Transitions from ARB_DGNT:
- On ACCESS with word_cnt==DBLK_WORDS-1, go to ARB_IDLE and clear word_cnt. If iREN is high, starve_cnt increments (saturating).
- On ACCESS otherwise, increment word_cnt and stay in ARB_DGNT.
- If dREN and dWEN both drop (for example a single flush-counter write or a halt), go to ARB_IDLE and clear word_cnt. This partial block does not count toward starvation.

Outputs (combinational from state):
- In ARB_IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1.
- In ARB_IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, iwait=(ramstate!=ACCESS), dwait=1.
- In ARB_DGNT: ramWEN=dWEN, ramREN=dREN&!dWEN, ramaddr=daddr, ramstore=dstore, dwait=(ramstate!=ACCESS), iwait=1.
- ERROR is treated as not complete. The requester keeps waiting and the grant is held.

## Timing
- Reset (nRST low, asynchronous): state=ARB_IDLE, word_cnt=0, starve_cnt=0. Outputs take their ARB_IDLE values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Arbitration latency is one cycle. A request sampled in ARB_IDLE at edge N drives the RAM from cycle N+1.
- Completion: the wait output is low in the same cycle ramstate==ACCESS. The requester advances at the next edge.
- Back-to-back block words: in ARB_DGNT the second word is presented the cycle after the first ACCESS, with no return to ARB_IDLE.
- After any grant ends, the FSM spends one cycle in ARB_IDLE before the next grant, including re-grants to the same requester.
- Simultaneous iREN and dREN in ARB_IDLE: dcache wins unless starve_cnt==STARVE_MAX.
- Reset asserted mid-block: the transfer is abandoned, counters clear, and RAM enables drop immediately. The caches handle the retry.

## Structure
- arb_state_t belongs in cache_pkg next to istate_t and dstate_t.
- ramstate_t and word_t come from cpu_types_pkg.
- The design is a single module with no sub-module. The FSM and counters are in one always_ff; output muxing is in one always_comb.

## Test plan
- Icache only: iREN=1, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles → ramaddr=0x40 from cycle 1, iwait low exactly one cycle, then ARB_IDLE.
- Dcache write-back: dWEN=1, daddr 0x100 then 0x104, iREN=1 throughout → ramWEN for both words with no icache grant between them. The icache is granted after the block; iwait stays 1 until then.
- Dcache load, simultaneous dREN and dWEN: dREN=dWEN=1 → ramWEN=1, ramREN=0.
- Starvation: iREN held while the dcache issues 5 consecutive blocks → icache is granted after exactly 4 completed blocks, ahead of the pending 5th; starve_cnt reads 0 after the icache ACCESS.
- Partial grant: dWEN for one word, then dWEN drops → FSM returns to ARB_IDLE with word_cnt=0 and starve_cnt unchanged.
- Reset mid-block: nRST low after the first ACCESS of a load → ramREN=0 and iwait=dwait=1 asynchronously. After release, a fresh dREN restarts with word_cnt=0.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : controller state types for the icache, dcache and RAM arbiter
// Rev 1.0
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_FETCH = 2'd1
    } istate_t;

    typedef enum logic [2:0] {
        D_IDLE   = 3'd0,
        D_WB1    = 3'd1,
        D_WB2    = 3'd2,
        D_LOAD1  = 3'd3,
        D_LOAD2  = 3'd4,
        D_FLUSH  = 3'd5,
        D_HALT   = 3'd6
    } dstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IGNT = 2'd1,
        ARB_DGNT = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU datapath and memory-interface types
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// cache_mem_arbiter : shares one RAM port between icache and dcache, dcache
//                     priority, block-locked dcache grant, icache anti-starvation
// Rev 1.0
// ============================================================================
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int DBLK_WORDS = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int WCW = (DBLK_WORDS > 1) ? $clog2(DBLK_WORDS) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] c_LAST_WORD  = WCW'(DBLK_WORDS - 1);
    localparam logic [SCW-1:0] c_STARVE_MAX = SCW'(STARVE_MAX);

    arb_state_t     r_state;
    logic [WCW-1:0] r_word_cnt;
    logic [SCW-1:0] r_starve_cnt;

    logic w_dreq;
    logic w_access;
    logic w_istarved;

    assign w_dreq     = dREN | dWEN;
    assign w_access   = (ramstate == ACCESS);
    assign w_istarved = iREN && (r_starve_cnt == c_STARVE_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ARB_IDLE;
            r_word_cnt   <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_dreq && !w_istarved)
                        r_state <= ARB_DGNT;
                    else if (iREN)
                        r_state <= ARB_IGNT;
                end
                ARB_IGNT: begin
                    if (w_access) begin
                        r_state      <= ARB_IDLE;
                        r_starve_cnt <= '0;
                    end else if (!iREN) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_DGNT: begin
                    if (w_access) begin
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_state    <= ARB_IDLE;
                            r_word_cnt <= '0;
                            // Only full blocks that overlapped a pending fetch count
                            if (iREN && (r_starve_cnt != c_STARVE_MAX))
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end else if (!w_dreq) begin
                        r_state    <= ARB_IDLE;
                        r_word_cnt <= '0;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            ARB_IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !w_access;
            end
            ARB_DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !w_access;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cache_mem_arbiter : directed bench with RAM responder, cache agents and
//                        a grant-level reference model
// Rev 1.0
// ============================================================================
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DBLK = 2;
    localparam int SMAX = 4;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    cache_mem_arbiter #(.DBLK_WORDS(DBLK), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_str(string nm, string act, string exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", nm, act, exp);
        end
    endtask

    // RAM responder: BUSY for ram_lat cycles, optional ERROR cycles, then ACCESS
    int ram_lat  = 2;
    int err_left = 0;
    int ram_cnt  = 0;
    logic ram_en;
    assign ram_en  = ramREN | ramWEN;
    assign ramload = ramaddr ^ 32'hA5A5_0000;

    always_comb begin
        ramstate = FREE;
        if (ram_en)
            ramstate = (ram_cnt >= ram_lat) ? ((err_left > 0) ? ERROR : ACCESS) : BUSY;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                               ram_cnt <= 0;
        else if (!ram_en || ramstate == ACCESS)  ram_cnt <= 0;
        else if (ramstate == ERROR)              err_left <= err_left - 1;
        else                                     ram_cnt <= ram_cnt + 1;
    end

    // Cache agents: dcache runs a queue of blocks (words==0 is a one-cycle gap)
    typedef struct {
        logic [31:0] base;
        logic        wen;
        logic        ren;
        int          words;
    } dop_t;

    dop_t        dq[$];
    int          d_word = 0;
    int          i_left = 0;
    logic [31:0] i_next = '0;
    logic        s_iwait = 1'b1, s_dwait = 1'b1;

    task automatic agent_drive();
        if (dq.size() > 0 && dq[0].words > 0) begin
            dWEN   = dq[0].wen;
            dREN   = dq[0].ren;
            daddr  = dq[0].base + 32'(4 * d_word);
            dstore = ~daddr;
        end else begin
            dWEN = 1'b0; dREN = 1'b0; daddr = '0; dstore = '0;
        end
        iREN  = (i_left > 0);
        iaddr = i_next;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (dq.size() > 0 && dq[0].words == 0) begin
            void'(dq.pop_front());
        end else if (!s_dwait && dq.size() > 0) begin
            d_word++;
            if (d_word == dq[0].words) begin
                void'(dq.pop_front());
                d_word = 0;
            end
        end
        if (!s_iwait && i_left > 0) begin
            i_left--;
            i_next += 32'd4;
        end
        agent_drive();
    endtask

    task automatic run_quiet(string nm, int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (dq.size() == 0 && i_left == 0) break;
            step();
        end
        n_chk++;
        if (k == budget) begin
            n_err++;
            $display("FAIL %s_timeout: agents still busy after %0d cycles, required idle", nm, budget);
        end
        step();
        step();
    endtask

    // Reference model: owner 0=none 1=icache 2=dcache, words done, starvation
    int          m_own = 0, m_words = 0, m_starve = 0;
    string       glog = "";
    logic [31:0] alog[$];
    int          wen_acc = 0, ren_acc = 0;
    logic        e_ren, e_wen, e_iw, e_dw, m_acc;
    logic [31:0] e_addr, e_store;

    always @(negedge CLK) begin
        s_iwait = iwait;
        s_dwait = dwait;
        if (!nRST) begin
            m_own = 0; m_words = 0; m_starve = 0;
        end
        m_acc = (ramstate == ACCESS);
        e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr = '0; e_store = '0;
        if (m_own == 1) begin
            e_ren = iREN; e_addr = iaddr; e_iw = !m_acc;
        end else if (m_own == 2) begin
            e_wen = dWEN; e_ren = dREN && !dWEN;
            e_addr = daddr; e_store = dstore; e_dw = !m_acc;
        end
        chk("ctl", {28'd0, ramREN, ramWEN, iwait, dwait}, {28'd0, e_ren, e_wen, e_iw, e_dw});
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iload", iload, ramload);
        chk("dload", dload, ramload);

        if (nRST) begin
            if (!iwait) begin glog = {glog, "I"}; alog.push_back(ramaddr); end
            if (!dwait) begin
                glog = {glog, "D"}; alog.push_back(ramaddr);
                wen_acc += int'(ramWEN); ren_acc += int'(ramREN);
            end
            if (m_own == 0) begin
                if ((dREN || dWEN) && !(iREN && m_starve >= SMAX)) m_own = 2;
                else if (iREN) m_own = 1;
            end else if (m_own == 1) begin
                if (m_acc) begin m_own = 0; m_starve = 0; end
                else if (!iREN) m_own = 0;
            end else begin
                if (m_acc) begin
                    m_words++;
                    if (m_words == DBLK) begin
                        m_own = 0; m_words = 0;
                        if (iREN && m_starve < SMAX) m_starve++;
                    end
                end else if (!(dREN || dWEN)) begin
                    m_own = 0; m_words = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        glog = ""; alog.delete(); wen_acc = 0; ren_acc = 0;
    endtask

    task automatic push_blk(logic [31:0] base, logic wen, logic ren, int words);
        dop_t op;
        op.base = base; op.wen = wen; op.ren = ren; op.words = words;
        dq.push_back(op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low;

        @(posedge CLK); #1;
        chk("rst_ctl", {28'd0, ramREN, ramWEN, iwait, dwait}, 32'h3);
        chk("rst_addr", ramaddr, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Icache only: grant one cycle after request, two BUSY cycles, then ACCESS
        i_left = 1; i_next = 32'h40; agent_drive();
        lat = 0; low = 0;
        for (int k = 1; k <= 8; k++) begin
            step(); #1;
            if (k == 1) begin
                chk("t1_addr_c1", ramaddr, 32'h40);
                chk("t1_ren_c1", {31'd0, ramREN}, 32'd1);
            end
            if (!iwait) begin
                low++;
                if (lat == 0) lat = k;
            end
        end
        chk("t1_latency", lat, 3);
        chk("t1_iwait_low_cycles", low, 1);

        // Dcache write-back with a pending fetch; two ERROR cycles on word 0
        clear_logs();
        err_left = 2;
        push_blk(32'h100, 1'b1, 1'b0, 2);
        i_left = 1; i_next = 32'h200; agent_drive();
        run_quiet("t2", 60);
        chk_str("t2_order", glog, "DDI");
        chk("t2_wen_words", wen_acc, 2);
        chk("t2_addr0", alog[0], 32'h100);
        chk("t2_addr1", alog[1], 32'h104);
        chk("t2_addr2", alog[2], 32'h200);

        // Simultaneous dREN and dWEN: write wins
        clear_logs();
        push_blk(32'h300, 1'b1, 1'b1, 2); agent_drive();
        run_quiet("t3", 40);
        chk("t3_wen_words", wen_acc, 2);
        chk("t3_ren_words", ren_acc, 0);

        // Starvation: icache forced in after four completed blocks, twice over
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            for (int b = 0; b < 5; b++) push_blk(32'h400 + 32'(8 * b), 1'b0, 1'b1, 2);
            i_left = 1; i_next = 32'h500; agent_drive();
            run_quiet("t4", 150);
            chk_str("t4_order", glog, "DDDDDDDDIDD");
            chk("t4_iaddr", alog[8], 32'h500);
        end

        // Partial block does not count toward starvation
        clear_logs();
        for (int b = 0; b < 3; b++) push_blk(32'h800 + 32'(8 * b), 1'b1, 1'b0, 2);
        push_blk(32'h900, 1'b1, 1'b0, 1);
        push_blk(32'h0, 1'b0, 1'b0, 0);
        for (int b = 0; b < 2; b++) push_blk(32'hA00 + 32'(8 * b), 1'b0, 1'b1, 2);
        i_left = 1; i_next = 32'hB00; agent_drive();
        run_quiet("t5", 200);
        chk_str("t5_order", glog, "DDDDDDDDDIDD");

        // Reset in the middle of a load block
        clear_logs();
        push_blk(32'h600, 1'b0, 1'b1, 2); agent_drive();
        begin
            int k;
            for (k = 0; k < 40 && glog.len() == 0; k++) step();
            chk("t6_first_word_seen", glog.len(), 1);
        end
        #3;
        chk("t6_pre_ren", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0;
        dq.delete(); d_word = 0; i_left = 0; agent_drive();
        #1;
        chk("t6_async_ctl", {28'd0, ramREN, ramWEN, iwait, dwait}, 32'h3);
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        clear_logs();
        push_blk(32'h700, 1'b0, 1'b1, 2); agent_drive();
        run_quiet("t6", 40);
        chk_str("t6_order", glog, "DD");
        chk("t6_addr0", alog[0], 32'h700);
        chk("t6_addr1", alog[1], 32'h704);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
